// File: rtl/rrag_mem_ctrl_pkg.sv
// Shared types and constants for the RrAg->MEM stage controller.
// Holds the stage FSM encoding and the latch valid-bit rule.
package rrag_mem_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    REP = 2'd1,
    EXC = 2'd2
  } state_e;

  // A REP with a zero count is squashed unless it carries an exception.
  function automatic logic lvld_f(
    input logic v,
    input logic rep,
    input logic ie,
    input logic zero
  );
    return v & (ie | ~(rep & zero));
  endfunction

endpackage

// File: rtl/rrag_mem_ctrl_rep_counter.sv
// Loadable REP iteration down-counter with zero/one detect.
// Priority is clear, then load, then decrement; never wraps below zero.
module rrag_mem_ctrl_rep_counter
  import rrag_mem_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == W'(1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rrag_mem_ctrl.sv
// RrAg->MEM latch controller: load/stall generation,
// REP sequencing and exception freeze until flush.
module rrag_mem_ctrl
  import rrag_mem_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid_in,
  input  logic             is_rep_in,
  input  logic [CNT_W-1:0] rep_num_in,
  input  logic             IE_in,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             latch_ld,
  output logic             latch_vld,
  output logic             rrag_stall,
  output logic             rep_active,
  output logic [CNT_W-1:0] rep_cnt,
  output logic             rep_last,
  output logic             rep_done,
  output logic             ie_hold
);

  state_e     state_q;
  logic       vld_q;
  logic       rep_done_q;
  logic [CNT_W-1:0] cnt;
  logic       cnt_zero;
  logic       cnt_one;

  logic num_zero;
  logic accept;
  logic rule_vld;
  logic rep_end;
  logic ld_rep;
  logic ld_exc;
  logic dec;

  assign num_zero = (rep_num_in == '0);
  assign rule_vld = lvld_f(valid_in, is_rep_in,
                           IE_in, num_zero);
  assign accept   = latch_ld & valid_in & ~flush;
  assign rep_end  = (state_q == REP) & mem_ready
                  & cnt_one;
  assign ld_exc   = accept & IE_in;
  assign ld_rep   = accept & ~IE_in & is_rep_in
                  & ~num_zero;
  assign dec      = (state_q == REP) & mem_ready
                  & ~flush;

  always_comb begin
    latch_ld   = 1'b0;
    latch_vld  = 1'b0;
    rrag_stall = 1'b1;
    if (clr) begin
      if (flush) begin
        latch_ld = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            latch_ld  = ~vld_q | mem_ready;
            latch_vld = rule_vld;
          end
          REP: begin
            latch_ld  = rep_end;
            latch_vld = rule_vld & rep_end;
          end
          default: ;
        endcase
      end
      rrag_stall = ~latch_ld;
    end
  end

  rrag_mem_ctrl_rep_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (clr),
    .clr_i   (flush),
    .ld_i    (ld_rep),
    .ld_val_i(rep_num_in),
    .dec_i   (dec),
    .cnt_o   (cnt),
    .zero_o  (cnt_zero),
    .one_o   (cnt_one)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= RUN;
      vld_q      <= 1'b0;
      rep_done_q <= 1'b0;
    end else begin
      rep_done_q <= ~flush & (rep_end
                  | (accept & ~IE_in
                     & is_rep_in & num_zero));
      if (flush) begin
        state_q <= RUN;
        vld_q   <= 1'b0;
      end else if (state_q != EXC && latch_ld) begin
        if (ld_exc) begin
          state_q <= EXC;
          vld_q   <= 1'b1;
        end else if (ld_rep) begin
          state_q <= REP;
          vld_q   <= 1'b1;
        end else begin
          state_q <= RUN;
          vld_q   <= latch_vld;
        end
      end
    end
  end

  assign rep_cnt    = clr ? cnt : '0;
  assign rep_active = clr & (state_q == REP);
  assign rep_last   = clr & (state_q == REP)
                    & cnt_one;
  assign ie_hold    = clr & (state_q == EXC);
  assign rep_done   = clr & rep_done_q;

endmodule

// File: tb/tb_rrag_mem_ctrl.sv
// Randomized bench for rrag_mem_ctrl against a latch-occupancy model.
// Directed test-plan sequences run first, then random traffic.
module tb_rrag_mem_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             clr;
  logic             valid_in;
  logic             is_rep_in;
  logic [CNT_W-1:0] rep_num_in;
  logic             IE_in;
  logic             mem_ready;
  logic             flush;
  logic             latch_ld;
  logic             latch_vld;
  logic             rrag_stall;
  logic             rep_active;
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_last;
  logic             rep_done;
  logic             ie_hold;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_hv;
  bit          m_exc;
  bit          m_done;
  logic [31:0] m_rem;

  always #5 clk = ~clk;

  rrag_mem_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .valid_in  (valid_in),
    .is_rep_in (is_rep_in),
    .rep_num_in(rep_num_in),
    .IE_in     (IE_in),
    .mem_ready (mem_ready),
    .flush     (flush),
    .latch_ld  (latch_ld),
    .latch_vld (latch_vld),
    .rrag_stall(rrag_stall),
    .rep_active(rep_active),
    .rep_cnt   (rep_cnt),
    .rep_last  (rep_last),
    .rep_done  (rep_done),
    .ie_hold   (ie_hold)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hv   = 0;
    m_exc  = 0;
    m_done = 0;
    m_rem  = 0;
  endtask

  task automatic check_reset_outs();
    check("rst_ld", {31'd0, latch_ld}, 0);
    check("rst_lvld", {31'd0, latch_vld}, 0);
    check("rst_stall", {31'd0, rrag_stall}, 1);
    check("rst_act", {31'd0, rep_active}, 0);
    check("rst_cnt", rep_cnt, 0);
    check("rst_last", {31'd0, rep_last}, 0);
    check("rst_done", {31'd0, rep_done}, 0);
    check("rst_ie", {31'd0, ie_hold}, 0);
  endtask

  task automatic step(input logic v, input logic r,
                      input logic [31:0] n,
                      input logic ie, input logic mr,
                      input logic fl);
    bit ld_e;
    bit lv_e;
    bit squash;
    valid_in   = v;
    is_rep_in  = r;
    rep_num_in = n;
    IE_in      = ie;
    mem_ready  = mr;
    flush      = fl;
    squash = r && (n == 0) && !ie;
    if (fl)              ld_e = 1;
    else if (m_exc)      ld_e = 0;
    else if (m_rem != 0) ld_e = mr && (m_rem == 1);
    else                 ld_e = !m_hv || mr;
    lv_e = !fl && v && !squash;
    #3;
    check("ld", {31'd0, latch_ld}, {31'd0, ld_e});
    check("stall", {31'd0, rrag_stall},
          {31'd0, !ld_e});
    if (ld_e || (m_rem == 0 && !m_exc))
      check("lvld", {31'd0, latch_vld},
            {31'd0, lv_e});
    check("cnt", rep_cnt, m_rem);
    check("act", {31'd0, rep_active},
          {31'd0, m_rem != 0});
    check("last", {31'd0, rep_last},
          {31'd0, m_rem == 1});
    check("ie", {31'd0, ie_hold}, {31'd0, m_exc});
    check("done", {31'd0, rep_done}, {31'd0, m_done});
    @(posedge clk);
    m_done = 0;
    if (fl) begin
      m_hv  = 0;
      m_exc = 0;
      m_rem = 0;
    end else if (!m_exc) begin
      if (m_rem != 0 && mr) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end
      if (ld_e) begin
        if (!v) m_hv = 0;
        else if (ie) begin
          m_hv  = 1;
          m_exc = 1;
        end else if (squash) begin
          m_hv   = 0;
          m_done = 1;
        end else if (r) begin
          m_hv  = 1;
          m_rem = n;
        end else m_hv = 1;
      end
    end
    #1;
  endtask

  initial begin
    clr = 0;
    valid_in = 0; is_rep_in = 0; rep_num_in = 0;
    IE_in = 0; mem_ready = 0; flush = 0;
    model_reset();
    #12;
    check_reset_outs();
    @(posedge clk); #1;
    clr = 1;
    // streaming
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0);
    // back-pressure
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    // REP count 3, rep_num changes ignored after accept
    step(1, 1, 3, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 7, 0, 1, 0);
    // REP zero
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // exception, freeze, then flush
    step(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    // flush mid-REP
    step(1, 1, 10, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // async reset mid-REP
    step(1, 1, 10, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    #2;
    clr = 0;
    #1;
    check_reset_outs();
    model_reset();
    @(posedge clk); #1;
    clr = 1;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] n;
      n = ($urandom_range(0, 9) == 0) ? 32'd0
        : 32'($urandom_range(1, 5));
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 4) == 0,
           n,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
